// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the core run/stop controller.
package core_run_ctrl_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    // Reasons for the most recent stop
    localparam logic [1:0] STOP_RESET = 2'd0;
    localparam logic [1:0] STOP_HALT  = 2'd1;
    localparam logic [1:0] STOP_BRK   = 2'd2;
    localparam logic [1:0] STOP_STEP  = 2'd3;

    // Core is clocked forward only in the running states
    function automatic logic state_enabled(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/run_ctrl_resume_sync.sv
// Resume button conditioning: 2-flop synchronizer, optional debounce
// (RUN_CTRL_DEBOUNCE_EN), and a registered rising-edge detector that emits
// a single-cycle pulse per press.
module run_ctrl_resume_sync #(
    parameter int unsigned DebounceCnt = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_resume,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_prev;
    logic r_pulse;
    logic w_level;

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_resume;
            r_sync2 <= r_sync1;
        end
    end

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DebounceCnt + 1);

    logic [CntW-1:0] r_deb_cnt;
    logic            r_deb;

    // Accept a new level only after it has held for DebounceCnt cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb_cnt <= '0;
            r_deb     <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == CntW'(DebounceCnt - 1)) begin
            r_deb_cnt <= '0;
            r_deb     <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + CntW'(1);
        end
    end

    assign w_level = r_deb;
`else
    logic w_unused_deb;
    assign w_unused_deb = ^DebounceCnt;
    assign w_level      = r_sync2;
`endif

    // Registered rising-edge detect: one pulse per low-to-high transition
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level_prev <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_level_prev <= w_level;
            r_pulse      <= w_level & ~r_level_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/stop scheduler driving the core and performance-counter enable.
// Supports free run, N-cycle stepping, PC breakpoint and halt stops.
// Optional resume debounce is enabled with RUN_CTRL_DEBOUNCE_EN.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int unsigned StepBit     = 16,
    parameter int unsigned DebounceCnt = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_resume,
    input  logic               i_step_mode,
    input  logic [StepBit-1:0] i_step_cnt,
    input  logic               i_brk_en,
    input  logic [31:0]        i_brk_pc,
    input  logic [31:0]        i_dbg_pc,
    input  logic               i_halt,
    output logic               o_en,
    output logic [1:0]         o_stop_cause,
    output logic [31:0]        o_run_cycles
);

    logic [1:0]         r_state;
    logic [1:0]         r_stop_cause;
    logic [31:0]        r_run_cycles;
    logic [StepBit-1:0] r_step_cnt;
    logic               r_skip;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_cause_nxt;
    logic [StepBit-1:0] w_step_nxt;
    logic               w_skip_nxt;
    logic               w_resume_pulse;
    logic               w_en;
    logic               w_brk_hit;

    run_ctrl_resume_sync #(
        .DebounceCnt (DebounceCnt)
    ) u_resume_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_resume (i_resume),
        .o_pulse  (w_resume_pulse)
    );

    assign w_en      = state_enabled(r_state);
    // Skip suppresses the breakpoint we just resumed from for one cycle
    assign w_brk_hit = i_brk_en && (i_dbg_pc == i_brk_pc) && !r_skip;

    // Next-state: start on resume, stop on halt > breakpoint > step exhausted
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_stop_cause;
        w_step_nxt  = r_step_cnt;
        w_skip_nxt  = r_skip;
        case (r_state)
            ST_IDLE, ST_STOP: begin
                if (w_resume_pulse) begin
                    w_skip_nxt = (r_state == ST_STOP) && (r_stop_cause == STOP_BRK);
                    if (i_step_mode) begin
                        w_state_nxt = ST_STEP;
                        w_step_nxt  = (i_step_cnt == '0) ? StepBit'(1) : i_step_cnt;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_skip_nxt = 1'b0;
                if (i_halt) begin
                    w_state_nxt = ST_STOP;
                    w_cause_nxt = STOP_HALT;
                end else if (w_brk_hit) begin
                    w_state_nxt = ST_STOP;
                    w_cause_nxt = STOP_BRK;
                end else if (r_state == ST_STEP) begin
                    if (r_step_cnt == StepBit'(1)) begin
                        w_state_nxt = ST_STOP;
                        w_cause_nxt = STOP_STEP;
                    end else begin
                        w_step_nxt = r_step_cnt - StepBit'(1);
                    end
                end
            end
        endcase
    end

    // State, step counter, skip flag and enabled-cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_stop_cause <= STOP_RESET;
            r_step_cnt   <= '0;
            r_skip       <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stop_cause <= w_cause_nxt;
            r_step_cnt   <= w_step_nxt;
            r_skip       <= w_skip_nxt;
            if (w_en) begin
                r_run_cycles <= r_run_cycles + 32'd1;
            end
        end
    end

    assign o_en         = w_en;
    assign o_stop_cause = r_stop_cause;
    assign o_run_cycles = r_run_cycles;

endmodule
